execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values are 8 to 64.
REQ-002 Parameter FUNCT_W, default 6: width of the funct field taken from extended_offset[FUNCT_W-1:0].
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  operand bundle present.
REQ-006 in_ready  out  1  stage can accept a bundle this cycle.
REQ-007 read_data_1  in  WIDTH  ALU operand A.
REQ-008 read_data_2  in  WIDTH  ALU operand B when alu_src=0.
REQ-009 extended_offset  in  WIDTH  sign-extended immediate; operand B when alu_src=1; funct source.
REQ-010 old_address  in  WIDTH  PC+4 of the instruction.
REQ-011 alu_op  in  2  00 add, 01 sub, 10 decode funct, 11 illegal.
REQ-012 alu_src  in  1  operand-B select.
REQ-013 out_valid  out  1  result bundle present.
REQ-014 out_ready  in  1  downstream accepts the bundle.
REQ-015 alu_result  out  WIDTH  registered ALU result.
REQ-016 zero  out  1  alu_result == 0.
REQ-017 new_address  out  WIDTH  registered branch target.
REQ-018 illegal  out  1  the bundle carried an unsupported operation.

Function
REQ-019 Transfer-in occurs when in_valid && in_ready; transfer-out occurs when out_valid && out_ready.
REQ-020 in_ready SHALL be state==IDLE && (!out_valid || out_ready), so a transfer-in and a transfer-out can occur in the same cycle.
REQ-021 Operand B SHALL be read_data_2 when alu_src=0, otherwise extended_offset.
REQ-022 Decode: alu_op 00 → ADD; alu_op 01 → SUB; alu_op 10 → funct decode per REQ-023; alu_op 11 → illegal.
REQ-023 Funct codes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 011000 MUL; any other code → illegal.
REQ-024 An illegal bundle SHALL be accepted, with alu_result=0, zero=1, illegal=1.
REQ-025 ADD, SUB and MUL wrap modulo 2^WIDTH; SLT is a signed compare returning 1 or 0 and SHALL be correct under subtraction overflow.
REQ-026 MUL returns the low WIDTH bits of the signed product.
REQ-027 new_address SHALL be old_address + (extended_offset << 2) modulo 2^WIDTH, computed for every bundle.
REQ-028 State machine states: IDLE, MUL_BUSY.
REQ-029 In IDLE, a transfer-in of a non-MUL operation SHALL load the outputs and set out_valid=1 on the next edge (latency 1).
REQ-030 In IDLE, a transfer-in of MUL SHALL go to MUL_BUSY and run a shift-add sequence of WIDTH cycles.
REQ-031 MUL_BUSY SHALL return to IDLE with out_valid=1 on the WIDTH-th cycle (total latency WIDTH+1); in_ready=0 throughout MUL_BUSY.
REQ-032 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-033 out_valid SHALL clear after a transfer-out unless a new transfer-in occurs in the same cycle.

Reset
REQ-034 When rst=1 at an edge: state=IDLE, out_valid=0, alu_result=0, zero=1, new_address=0, illegal=0, multiplier registers cleared.
REQ-035 Reset SHALL take priority over every other event, abort any MUL in progress, and drop the pending output without emitting it.
REQ-036 in_ready SHALL be 0 while rst=1.

Configuration
REQ-037 Macro EXECUTE_STAGE_MUL_EN: when defined, MUL and the MUL_BUSY state are built in.
REQ-038 When EXECUTE_STAGE_MUL_EN is undefined, funct 011000 SHALL decode as illegal, no multiplier logic is generated, and every operation has latency 1.

Verification
REQ-039 WIDTH=32, alu_op=10, funct 100010, A=5, B=5 → next cycle out_valid=1, alu_result=0, zero=1.
REQ-040 alu_op=10, funct 101010, A=0x80000000, B=1 → alu_result=1 (signed); A=1, B=0x80000000 → alu_result=0.
REQ-041 MUL_EN, A=7, B=-3 → in_ready=0 for 32 cycles, then alu_result=0xFFFFFFEB after 33 cycles.
REQ-042 out_ready held 0 for 4 cycles with back-to-back in_valid → outputs frozen, in_ready=0, no bundle lost; order preserved on release.
REQ-043 old_address=0xFFFFFFFC, extended_offset=1 → new_address=0 (wrap); alu_op=11 → illegal=1, alu_result=0.
REQ-044 rst asserted in cycle 10 of a MUL → next cycle state=IDLE, out_valid=0, no result emitted.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: operand select, ALU, branch target, valid/ready handshake.
// Define EXECUTE_STAGE_MUL_EN to build in the multi-cycle shift-add MUL.
module execute_stage #(
   parameter int WIDTH   = 32,
   parameter int FUNCT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] read_data_1,
   input  logic [WIDTH-1:0] read_data_2,
   input  logic [WIDTH-1:0] extended_offset,
   input  logic [WIDTH-1:0] old_address,
   input  logic [1:0]       alu_op,
   input  logic             alu_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [WIDTH-1:0] new_address,
   output logic             illegal
);

   typedef enum logic {IDLE, MUL_BUSY} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MUL, OP_ILL
   } op_t;

   state_t             state;
   op_t                op;
   logic [FUNCT_W-1:0] funct;
   logic [WIDTH-1:0]   operand_b;
   logic [WIDTH-1:0]   result;

   assign funct     = extended_offset[FUNCT_W-1:0];
   assign operand_b = alu_src ? extended_offset : read_data_2;
   assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      op = OP_ILL;
      case (alu_op)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b10: begin
            case (funct)
               FUNCT_W'(6'b100000): op = OP_ADD;
               FUNCT_W'(6'b100010): op = OP_SUB;
               FUNCT_W'(6'b100100): op = OP_AND;
               FUNCT_W'(6'b100101): op = OP_OR;
               FUNCT_W'(6'b100111): op = OP_NOR;
               FUNCT_W'(6'b101010): op = OP_SLT;
`ifdef EXECUTE_STAGE_MUL_EN
               FUNCT_W'(6'b011000): op = OP_MUL;
`endif
               default:             op = OP_ILL;
            endcase
         end
         default: op = OP_ILL;
      endcase
   end

   // Signed compare directly, so SLT stays correct when A-B would overflow.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = read_data_1 + operand_b;
         OP_SUB:  result = read_data_1 - operand_b;
         OP_AND:  result = read_data_1 & operand_b;
         OP_OR:   result = read_data_1 | operand_b;
         OP_NOR:  result = ~(read_data_1 | operand_b);
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(read_data_1) < $signed(operand_b))};
         default: result = '0;
      endcase
   end

`ifdef EXECUTE_STAGE_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mul_next;
   logic [CNT_W-1:0] cnt;

   // Low WIDTH bits of a two's-complement product equal those of the unsigned one.
   assign mul_next = acc + (mplier[0] ? mcand : '0);
`endif

   always_ff @(posedge clk) begin
      // NOTE: reset lives inside the clocked block (synchronous) and overrides every other update.
      if (rst) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         alu_result  <= '0;
         zero        <= 1'b1;
         new_address <= '0;
         illegal     <= 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
`endif
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  new_address <= old_address + (extended_offset << 2);
`ifdef EXECUTE_STAGE_MUL_EN
                  if (op == OP_MUL) begin
                     state  <= MUL_BUSY;
                     mcand  <= read_data_1;
                     mplier <= operand_b;
                     acc    <= '0;
                     cnt    <= '0;
                  end else
`endif
                  begin
                     alu_result <= result;
                     zero       <= (result == '0);
                     illegal    <= (op == OP_ILL);
                     out_valid  <= 1'b1;
                  end
               end
            end
`ifdef EXECUTE_STAGE_MUL_EN
            MUL_BUSY: begin
               acc    <= mul_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH-1)) begin
                  alu_result <= mul_next;
                  zero       <= (mul_next == '0);
                  illegal    <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage (WIDTH=32); MUL expectations follow
// EXECUTE_STAGE_MUL_EN the same way the design build does.
module tb_execute_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] read_data_1;
   logic [W-1:0] read_data_2;
   logic [W-1:0] extended_offset;
   logic [W-1:0] old_address;
   logic [1:0]   alu_op;
   logic         alu_src;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] alu_result;
   logic         zero;
   logic [W-1:0] new_address;
   logic         illegal;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ext;
      logic [W-1:0] old;
      logic [1:0]   op;
      logic         src;
   } stim_t;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic [W-1:0] naddr;
      logic         ill;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   execute_stage #(.WIDTH(W), .FUNCT_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .read_data_1     (read_data_1),
      .read_data_2     (read_data_2),
      .extended_offset (extended_offset),
      .old_address     (old_address),
      .alu_op          (alu_op),
      .alu_src         (alu_src),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .alu_result      (alu_result),
      .zero            (zero),
      .new_address     (new_address),
      .illegal         (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want)
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      else
         n_pass++;
   endtask

   function automatic stim_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] ext, input logic [W-1:0] old,
                                input logic [1:0] op, input logic src);
      stim_t s;
      s.a = a; s.b = b; s.ext = ext; s.old = old; s.op = op; s.src = src;
      return s;
   endfunction

   // Reference model written from the operation table.
   function automatic exp_t model(input stim_t s);
      exp_t               e;
      logic [W-1:0]       b;
      logic signed [63:0] prod;
      b       = s.src ? s.ext : s.b;
      e.naddr = s.old + {s.ext[W-3:0], 2'b00};
      e.ill   = 1'b0;
      e.res   = '0;
      case (s.op)
         2'd0: e.res = s.a + b;
         2'd1: e.res = s.a - b;
         2'd2: begin
            case (s.ext[5:0])
               6'h20: e.res = s.a + b;
               6'h22: e.res = s.a - b;
               6'h24: e.res = s.a & b;
               6'h25: e.res = s.a | b;
               6'h27: e.res = ~(s.a | b);
               6'h2a: e.res = (s.a[W-1] != b[W-1]) ? {31'd0, s.a[W-1]} : {31'd0, (s.a < b)};
`ifdef EXECUTE_STAGE_MUL_EN
               6'h18: begin
                  prod  = 64'($signed(s.a)) * 64'($signed(b));
                  e.res = prod[W-1:0];
               end
`endif
               default: e.ill = 1'b1;
            endcase
         end
         default: e.ill = 1'b1;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   task automatic drive(input stim_t s);
      read_data_1     = s.a;
      read_data_2     = s.b;
      extended_offset = s.ext;
      old_address     = s.old;
      alu_op          = s.op;
      alu_src         = s.src;
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Streams stim_q through the DUT with out_ready low for a window of cycles.
   task automatic run(input int stall_from, input int stall_len);
      int           c;
      exp_t         e;
      logic         held;
      logic [W-1:0] held_res;
      logic [W-1:0] held_addr;
      logic         held_zero;
      logic         held_ill;
      c    = 0;
      held = 1'b0;
      held_res = '0; held_addr = '0; held_zero = 1'b0; held_ill = 1'b0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && c < 500) begin
         out_ready = !(c >= stall_from && c < stall_from + stall_len);
         if (stim_q.size() > 0) begin
            drive(stim_q[0]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_res", alu_result, held_res);
            check("hold_zero", zero, held_zero);
            check("hold_addr", new_address, held_addr);
            check("hold_ill", illegal, held_ill);
         end
         held = out_valid && !out_ready;
         if (held) begin
            check("stall_in_ready", in_ready, 0);
            held_res = alu_result; held_zero = zero;
            held_addr = new_address; held_ill = illegal;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_res", alu_result, e.res);
               check("sb_zero", zero, e.zero);
               check("sb_addr", new_address, e.naddr);
               check("sb_ill", illegal, e.ill);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(stim_q.pop_front()));
         cycle();
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("drain", exp_q.size() + stim_q.size(), 0);
   endtask

   initial begin
      int busy;
      int emitted;
      stim_t mul_s;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(mk('0, '0, '0, '0, 2'd0, 1'b0));
      cycle();
      cycle();
      #1;
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_res", alu_result, 0);
      check("rst_zero", zero, 1);
      check("rst_addr", new_address, 0);
      check("rst_ill", illegal, 0);
      check("idle_in_ready", in_ready, 1);

      // funct SUB, 5-5: one-cycle latency, zero flag set, then valid clears.
      drive(mk(32'd5, 32'd5, 32'h22, 32'h0, 2'd2, 1'b0));
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1;
      check("lat1_valid", out_valid, 1);
      check("lat1_res", alu_result, 0);
      check("lat1_zero", zero, 1);
      cycle();
      #1;
      check("valid_clears", out_valid, 0);

      // 7 * -3 through funct 011000.
      mul_s = mk(32'd7, 32'hFFFF_FFFD, 32'h18, 32'h0, 2'd2, 1'b0);
      drive(mul_s);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1;
`ifdef EXECUTE_STAGE_MUL_EN
      busy = 0;
      while (!out_valid && busy < 100) begin
         if (!in_ready) busy++;
         cycle();
         #1;
      end
      check("mul_busy_cycles", busy, 32);
      check("mul_valid", out_valid, 1);
      check("mul_res", alu_result, 32'hFFFF_FFEB);
      check("mul_ill", illegal, 0);
`else
      check("mul_valid", out_valid, 1);
      check("mul_ill", illegal, 1);
      check("mul_res", alu_result, 0);
`endif
      cycle();

      // Reset ten cycles into a MUL (or with a stalled result pending) drops it.
      out_ready = 1'b0;
      drive(mul_s);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (9) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_res", alu_result, 0);
      out_ready = 1'b1;
      emitted = 0;
      repeat (40) begin
         cycle();
         #1;
         if (out_valid) emitted++;
      end
      check("abort_no_emit", emitted, 0);

      // Scoreboard stream, back-to-back, with a 4-cycle downstream stall.
      stim_q.push_back(mk(32'd5, 32'd5, 32'h22, 32'h100, 2'd2, 1'b0));
      stim_q.push_back(mk(32'h8000_0000, 32'd1, 32'h2a, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mk(32'd1, 32'h8000_0000, 32'h2a, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h2a, 32'h4, 2'd2, 1'b0));
      stim_q.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h2a, 32'h8, 2'd2, 1'b0));
      stim_q.push_back(mk(32'd3, 32'd4, 32'd1, 32'hFFFF_FFFC, 2'd0, 1'b0));
      stim_q.push_back(mk(32'd3, 32'd4, 32'h0, 32'h10, 2'd3, 1'b0));
      stim_q.push_back(mk(32'hF0F0_1234, 32'h0FF0_FF00, 32'h24, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mk(32'hF0F0_1234, 32'h0FF0_FF00, 32'h25, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mk(32'hF0F0_1234, 32'h0FF0_FF00, 32'h27, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mk(32'hFFFF_FFFF, 32'd1, 32'h20, 32'h20, 2'd2, 1'b0));
      stim_q.push_back(mk(32'd10, 32'd999, 32'hFFFF_FFFE, 32'h1000, 2'd0, 1'b1));
      stim_q.push_back(mk(32'd0, 32'd1, 32'h0, 32'h0, 2'd1, 1'b0));
      stim_q.push_back(mk(32'd9, 32'd2, 32'h3f, 32'h0, 2'd2, 1'b0));
      stim_q.push_back(mul_s);
      stim_q.push_back(mk(32'd100, 32'd23, 32'h7, 32'h40, 2'd0, 1'b0));
      for (int i = 0; i < 8; i++)
         stim_q.push_back(mk($urandom, $urandom, $urandom, $urandom,
                             2'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      run(3, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
